dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the DDS core. It steps the DDS output frequency from a start value to a stop value in fixed increments and holds each point for a programmable dwell time. Each new frequency is delivered to the DDS tuning logic over a load/ack handshake. It sits between the keypad/display front end, which supplies the parameters, and the phase-accumulator/ROM datapath, which consumes `freq_word`.

---
 rtl/dds_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS core: walks freq_word from start to stop
// in fixed steps, holding each point for a programmable dwell after the DDS acks it.
module dds_sweep_ctrl #(
    parameter int unsigned FW   = 20,
    parameter int unsigned DW   = 24,
    parameter int unsigned FMAX = 499999
) (
    input  logic          clkin_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          mode_i,
    input  logic [FW-1:0] f_start_i,
    input  logic [FW-1:0] f_stop_i,
    input  logic [FW-1:0] f_step_i,
    input  logic [DW-1:0] dwell_i,
    input  logic          freq_ack_i,
    output logic [FW-1:0] freq_word_o,
    output logic          freq_load_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [7:0]    sweep_cnt_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DWELL = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [FW-1:0] FMAX_W  = FW'(FMAX);
    localparam logic [DW-1:0] DW_ONE  = {{(DW-1){1'b0}}, 1'b1};

    logic [2:0]    state_q, state_d;
    logic [FW-1:0] cur_q, cur_d;
    logic [FW-1:0] fstart_q, fstart_d;
    logic [FW-1:0] fstop_q, fstop_d;
    logic [FW-1:0] fstep_q, fstep_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          up_q, up_d;
    logic [7:0]    swcnt_q, swcnt_d;

    logic [FW-1:0] start_clamp;
    logic [FW-1:0] stop_clamp;
    logic [FW:0]   sum;
    logic [FW:0]   diff;
    logic          at_stop;
    logic [FW-1:0] next_pt;

    // Next point is computed one bit wider so carry/borrow clamps to stop instead of wrapping.
    always_comb begin
        start_clamp = (f_start_i > FMAX_W) ? FMAX_W : f_start_i;
        stop_clamp  = (f_stop_i  > FMAX_W) ? FMAX_W : f_stop_i;
        sum         = {1'b0, cur_q} + {1'b0, fstep_q};
        diff        = {1'b0, cur_q} - {1'b0, fstep_q};
        at_stop     = (cur_q == fstop_q) || (fstep_q == '0);
        if (up_q) begin
            next_pt = (sum >= {1'b0, fstop_q}) ? fstop_q : sum[FW-1:0];
        end else begin
            next_pt = (diff[FW] || (diff[FW-1:0] <= fstop_q)) ? fstop_q : diff[FW-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        fstart_d = fstart_q;
        fstop_d  = fstop_q;
        fstep_d  = fstep_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        up_d     = up_q;
        swcnt_d  = swcnt_q;

        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        fstart_d = start_clamp;
                        fstop_d  = stop_clamp;
                        fstep_d  = f_step_i;
                        dwell_d  = dwell_i;
                        mode_d   = mode_i;
                        up_d     = (start_clamp <= stop_clamp);
                        cur_d    = start_clamp;
                        swcnt_d  = '0;
                        state_d  = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (freq_ack_i) begin
                        cnt_d   = (dwell_q == '0) ? DW_ONE : dwell_q;
                        state_d = S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (cnt_q <= DW_ONE) begin
                        state_d = S_NEXT;
                    end else begin
                        cnt_d = cnt_q - DW_ONE;
                    end
                end
                S_NEXT: begin
                    if (at_stop) begin
                        if (mode_q) begin
                            swcnt_d = swcnt_q + 8'd1;
                            cur_d   = fstart_q;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_FIN;
                        end
                    end else begin
                        cur_d   = next_pt;
                        state_d = S_LOAD;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkin_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            fstart_q <= '0;
            fstop_q  <= '0;
            fstep_q  <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            up_q     <= 1'b0;
            swcnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            fstart_q <= fstart_d;
            fstop_q  <= fstop_d;
            fstep_q  <= fstep_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            up_q     <= up_d;
            swcnt_q  <= swcnt_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them asynchronously.
    assign freq_word_o = cur_q;
    assign freq_load_o = (state_q == S_LOAD);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_FIN);
    assign sweep_cnt_o = swcnt_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweeps compared
// against a point-list model built from the sweep rules with plain integer arithmetic.
module tb_dds_sweep_ctrl;

    localparam int FW   = 20;
    localparam int DW   = 24;
    localparam int FMAX = 499999;

    logic          clkin;
    logic          rst;
    logic          start;
    logic          abort;
    logic          mode;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic          freq_ack;
    logic [FW-1:0] freq_word;
    logic          freq_load;
    logic          busy;
    logic          done;
    logic [7:0]    sweep_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_pts[$];

    dds_sweep_ctrl #(.FW(FW), .DW(DW), .FMAX(FMAX)) dut (
        .clkin_i     (clkin),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .mode_i      (mode),
        .f_start_i   (f_start),
        .f_stop_i    (f_stop),
        .f_step_i    (f_step),
        .dwell_i     (dwell),
        .freq_ack_i  (freq_ack),
        .freq_word_o (freq_word),
        .freq_load_o (freq_load),
        .busy_o      (busy),
        .done_o      (done),
        .sweep_cnt_o (sweep_cnt)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Point list of one sweep, from clamped endpoints with wide integer arithmetic.
    function automatic void build_points(input longint fs, input longint fe, input longint st);
        longint cur;
        exp_pts.delete();
        if (fs > FMAX) fs = FMAX;
        if (fe > FMAX) fe = FMAX;
        cur = fs;
        exp_pts.push_back(int'(cur));
        if (st == 0) return;
        while (cur != fe) begin
            if (fs <= fe) cur = (cur + st >= fe) ? fe : cur + st;
            else          cur = (cur - st <= fe) ? fe : cur - st;
            exp_pts.push_back(int'(cur));
        end
    endfunction

    // abort_after < 0: run to done (mode 0). Otherwise abort once that many points were acked.
    task automatic run_sweep(input int fs, input int fe, input int st, input int dw, input bit md,
                             input bit tie, input int mindel, input int maxdel, input int abort_after);
        int  len, idx, cyc, last_ack, load_age, del, dwl, ndone;
        bit  fin, abort_pend;
        build_points(fs, fe, st);
        len = exp_pts.size();
        dwl = (dw == 0) ? 1 : dw;
        @(negedge clkin);
        f_start = FW'(fs); f_stop = FW'(fe); f_step = FW'(st); dwell = DW'(dw); mode = md;
        start = 1'b1; freq_ack = tie;
        @(negedge clkin);
        start = 1'b0;
        f_start = FW'($urandom); f_stop = FW'($urandom); f_step = FW'($urandom);
        dwell = DW'($urandom_range(0, 9)); mode = ~md;
        idx = 0; cyc = 0; last_ack = -1; load_age = 0; ndone = 0; fin = 0; abort_pend = 0;
        del = tie ? 0 : $urandom_range(mindel, maxdel);
        while (!fin && cyc < 4000) begin
            if (freq_load) begin
                if (load_age == 0) begin
                    if (last_ack >= 0) check_eq("load_gap", cyc - last_ack, dwl + 2);
                    if (md) check_eq("sweep_cnt", sweep_cnt, (idx / len) % 256);
                end
                check_eq("freq_word", freq_word, exp_pts[idx % len]);
                check_eq("busy_load", busy, 1);
                if (load_age >= del) begin
                    freq_ack = 1'b1;
                    last_ack = cyc;
                    idx++;
                    load_age = 0;
                    del = tie ? 0 : $urandom_range(mindel, maxdel);
                end else begin
                    freq_ack = 1'b0;
                    load_age++;
                end
            end else begin
                freq_ack = tie ? 1'b1 : 1'($urandom_range(0, 1));
                if (done) begin
                    ndone++;
                    check_eq("done_at", cyc - last_ack, dwl + 2);
                    check_eq("n_points", idx, len);
                    if (abort_after < 0) fin = 1;
                end
                if (abort_pend) begin
                    abort = 1'b0;
                    check_eq("busy_abort", busy, 0);
                    check_eq("word_abort", freq_word, exp_pts[(idx - 1) % len]);
                    fin = 1;
                end else if (abort_after >= 0 && idx == abort_after) begin
                    abort = 1'b1;
                    abort_pend = 1;
                end
            end
            if (!fin) begin
                @(negedge clkin);
                cyc++;
            end
        end
        abort = 1'b0;
        if (!fin) check_eq("timeout", 0, 1);
        @(negedge clkin);
        check_eq("busy_end", busy, 0);
        check_eq("word_end", freq_word, exp_pts[(idx == 0 ? 0 : idx - 1) % len]);
        repeat (2) begin
            if (done) ndone++;
            @(negedge clkin);
        end
        check_eq("done_count", ndone, (abort_after < 0) ? 1 : 0);
    endtask

    initial begin
        int fs, fe, st, dw, r, rng;
        bit md;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; freq_ack = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        #12;
        check_eq("rst_word", freq_word, 0);
        check_eq("rst_load", freq_load, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cnt", sweep_cnt, 0);
        @(negedge clkin);
        rst = 1'b0;

        run_sweep(0, 1000, 300, 4, 0, 1, 0, 0, -1);
        run_sweep(5000, 4000, 400, 2, 0, 0, 0, 2, -1);
        run_sweep(100, 400, 100, 3, 0, 0, 3, 3, -1);
        run_sweep(10, 20, 10, 1, 1, 0, 0, 2, 7);
        run_sweep(100, 700000, 100000, 1, 0, 1, 0, 0, -1);
        run_sweep(1234, 9999, 0, 2, 0, 0, 0, 1, -1);
        run_sweep(FMAX - 1, FMAX, FMAX, 1, 0, 1, 0, 0, -1);
        run_sweep(300000, 0, FMAX, 0, 0, 0, 0, 1, -1);
        run_sweep(0, 1000, 100, 5, 0, 0, 0, 1, 2);

        // start and abort together while idle: stays idle
        @(negedge clkin);
        start = 1'b1; abort = 1'b1; f_start = 20'd50; f_stop = 20'd60; f_step = 20'd5;
        @(negedge clkin);
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", busy, 0);
        check_eq("start_abort_load", freq_load, 0);

        // asynchronous reset mid-handshake
        freq_ack = 1'b0; f_start = 20'd777; f_stop = 20'd900; f_step = 20'd1; dwell = 24'd3; mode = 1'b0;
        start = 1'b1;
        @(negedge clkin);
        start = 1'b0;
        check_eq("pre_rst_load", freq_load, 1);
        check_eq("pre_rst_word", freq_word, 777);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_load", freq_load, 0);
        check_eq("arst_word", freq_word, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_cnt", sweep_cnt, 0);
        @(negedge clkin);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            fs  = $urandom_range(0, 600000);
            fe  = $urandom_range(0, 600000);
            rng = ((fs > FMAX ? FMAX : fs) > (fe > FMAX ? FMAX : fe)) ?
                  (fs > FMAX ? FMAX : fs) - (fe > FMAX ? FMAX : fe) :
                  (fe > FMAX ? FMAX : fe) - (fs > FMAX ? FMAX : fs);
            r = $urandom_range(0, 9);
            if (r == 0)      st = 0;
            else if (r == 1) st = $urandom_range(1, (1 << FW) - 1);
            else             st = rng / $urandom_range(1, 10) + $urandom_range(1, 50);
            dw = $urandom_range(0, 4);
            md = 1'($urandom_range(0, 1));
            build_points(fs, fe, st);
            if (md) run_sweep(fs, fe, st, dw, 1, 0, 0, 2, exp_pts.size() * $urandom_range(1, 2) + 1);
            else    run_sweep(fs, fe, st, dw, 0, 1'($urandom_range(0, 1)), 0, 3, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
